ras_ckpt: RTL and testbench
===========================

Name: ras_ckpt

Overview:
- Parametrised return-address stack with speculative checkpoint/restore. It replaces the single-level rollback scheme of the current predictor.
- Fetch pushes the return address on call and pops on return. The top entry drives the jalr target prediction.
- On each predicted branch, fetch takes a checkpoint of the stack state and receives a tag. On mispredict, the backend restores by tag. On retire, the backend commits the oldest checkpoint in order.
- Sits in the prediction stage, next to the BTB and the direction predictor.

Parameters:
- DATA_WIDTH, 32, width of a stored return address.
- STACK_ADDR_WIDTH, 4, log2 of stack depth (depth = 16).
- CKPT_ID_WIDTH, 2, log2 of checkpoint slots (CKPT_NUM = 4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- push  in  1  call: push din.
- pop  in  1  return: pop top.
- din  in  DATA_WIDTH  return address (pc+4).
- top_data  out  DATA_WIDTH  current top entry (jalr prediction).
- top_valid  out  1  stack count != 0.
- underflow  out  1  registered 1-cycle pulse: pop attempted on empty stack.
- ckpt_save  in  1  allocate checkpoint this cycle.
- ckpt_id  out  CKPT_ID_WIDTH  tag allocated when ckpt_save && !ckpt_full (combinational = tail).
- ckpt_full  out  1  all CKPT_NUM slots outstanding.
- restore  in  1  mispredict recovery.
- restore_id  in  CKPT_ID_WIDTH  tag to restore to.
- commit  in  1  free oldest outstanding checkpoint.

Behaviour:
- Reset (rst_n low at posedge): clear sp, count, ckpt head/tail/ckpt_cnt and all slot valid bits. Clear underflow. Stack RAM contents are don't-care. top_valid=0, ckpt_full=0, ckpt_id=0.
- top_data = stack[sp], combinational, no latency. sp is the index of the top entry.
- Stack update priority per cycle: restore > push/pop. If restore is accepted, push and pop are ignored that cycle.
- push only: sp+1 (mod depth), write din at the new sp, count saturates at depth. Overflow silently overwrites the oldest entry (circular).
- pop only:
  - count>0: sp-1, count-1.
  - count==0: no change, underflow=1 next cycle.
- push && pop: write din at the current sp (replace top). sp and count unchanged.
- Checkpoint slot contents: {sp, count, top value}.
- Checkpoint capture: snapshot the NEXT-state stack values, i.e. after this cycle's push/pop is applied.
  - Accepted only if !ckpt_full. Then the slot at tail is written and marked valid, tail+1, and ckpt_id equals the old tail.
  - Save while ckpt_full is ignored, with no state change.
- Restore: accepted only if slot[restore_id] is valid.
  - Load sp and count from the slot, and write the saved top value into stack[saved sp]. This repairs a top overwritten by later speculative pushes.
  - Invalidate restore_id and all younger slots. Set tail=restore_id and ckpt_cnt=(restore_id-head) mod CKPT_NUM.
  - Restore of an invalid slot is ignored entirely, and push/pop proceed normally that cycle.
  - ckpt_save in the same cycle as an accepted restore is ignored.
- Commit: if ckpt_cnt>0, invalidate slot[head], head+1. Otherwise ignored.
- Commit together with accepted restore: the commit applies first to head, then the restore count is computed from the new head.
  - If restore_id==head, the restore still applies the stack state, and the checkpoint queue ends empty.
- Commit together with save: both apply, ckpt_cnt unchanged. A save is allowed when full only if a commit frees a slot that same cycle.
- ckpt_full = (ckpt_cnt == CKPT_NUM), registered count, combinational compare.
- All pointer arithmetic is modulo 2^width; wrap-around is natural.
- Reset mid-operation discards all outstanding checkpoints.

Test Plan:
- Reset, then push 0x100, 0x200, 0x300 -> top_data=0x300, count=3. Pop ×3 -> top_data sequence 0x200, 0x100, then top_valid=0. A 4th pop -> underflow pulse, sp unchanged.
- Push 17 values 0x1000+4i (i=0..16) at depth 16 -> count=16, top=0x1040. 16 pops return 0x1040 down to 0x1004. The 17th pop gives underflow.
- Push 0xA0, then save (id=0). Pop, then push 0xB0 (overwrites slot of 0xA0). Restore id=0 -> top_data=0xA0, count=1.
- Four saves with no commit -> ids 0,1,2,3 and ckpt_full=1. A fifth save is ignored. Commit+save in the same cycle -> new id=0, ckpt_full stays 1.
- Saves id0 (top 0x10), id1 (top 0x20), id2 (top 0x30). Restore id1 -> top=0x20, ids 1 and 2 invalid. A later restore id2 is ignored, and the next save returns id=1.
- push&&pop with din=0x55 on top 0x44 -> top=0x55, count unchanged. Restore plus push in the same cycle -> push dropped.

Source files
------------

// File: rtl/ras_ckpt.sv
// Return-address stack with speculative checkpoint/restore for the prediction stage.
// Checkpoints hold {sp, count, top}; restore repairs the top entry and squashes younger tags.
module ras_ckpt #(
    parameter int DATA_WIDTH       = 32,
    parameter int STACK_ADDR_WIDTH = 4,
    parameter int CKPT_ID_WIDTH    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic [DATA_WIDTH-1:0]    top_data,
    output logic                     top_valid,
    output logic                     underflow,
    input  logic                     ckpt_save,
    output logic [CKPT_ID_WIDTH-1:0] ckpt_id,
    output logic                     ckpt_full,
    input  logic                     restore,
    input  logic [CKPT_ID_WIDTH-1:0] restore_id,
    input  logic                     commit
);
    localparam int DEPTH    = 1 << STACK_ADDR_WIDTH;
    localparam int CKPT_NUM = 1 << CKPT_ID_WIDTH;
    localparam int CW       = STACK_ADDR_WIDTH + 1;
    localparam int QW       = CKPT_ID_WIDTH + 1;

    typedef logic [STACK_ADDR_WIDTH-1:0] sp_t;
    typedef logic [CKPT_ID_WIDTH-1:0]    id_t;
    typedef logic [CW-1:0]               cnt_t;
    typedef logic [DATA_WIDTH-1:0]       data_t;

    data_t              stack_q [DEPTH];
    data_t              stack_d [DEPTH];
    sp_t                sp_q, sp_d;
    cnt_t               count_q, count_d;
    logic               underflow_q, underflow_d;

    id_t                head_q, head_d;
    id_t                tail_q, tail_d;
    logic [QW-1:0]      ckpt_cnt_q, ckpt_cnt_d;
    logic [CKPT_NUM-1:0] slot_valid_q, slot_valid_d;
    sp_t                slot_sp_q  [CKPT_NUM];
    sp_t                slot_sp_d  [CKPT_NUM];
    cnt_t               slot_cnt_q [CKPT_NUM];
    cnt_t               slot_cnt_d [CKPT_NUM];
    data_t              slot_top_q [CKPT_NUM];
    data_t              slot_top_d [CKPT_NUM];

    logic restore_ok, commit_ok, save_ok;
    id_t  rpos;

    assign top_data  = stack_q[sp_q];
    assign top_valid = (count_q != '0);
    assign underflow = underflow_q;
    assign ckpt_id   = tail_q;
    assign ckpt_full = (ckpt_cnt_q == QW'(CKPT_NUM));

    assign restore_ok = restore && slot_valid_q[restore_id];
    assign commit_ok  = commit && (ckpt_cnt_q != '0);
    assign save_ok    = ckpt_save && !restore_ok && (!ckpt_full || commit_ok);
    assign rpos       = restore_id - head_q;

    always_comb begin
        stack_d      = stack_q;
        sp_d         = sp_q;
        count_d      = count_q;
        underflow_d  = 1'b0;
        head_d       = head_q;
        tail_d       = tail_q;
        ckpt_cnt_d   = ckpt_cnt_q;
        slot_valid_d = slot_valid_q;
        slot_sp_d    = slot_sp_q;
        slot_cnt_d   = slot_cnt_q;
        slot_top_d   = slot_top_q;

        if (restore_ok) begin
            sp_d          = slot_sp_q[restore_id];
            count_d       = slot_cnt_q[restore_id];
            stack_d[sp_d] = slot_top_q[restore_id];
        end else if (push && pop) begin
            stack_d[sp_q] = din;
        end else if (push) begin
            sp_d          = sp_q + sp_t'(1);
            stack_d[sp_d] = din;
            if (count_q != cnt_t'(DEPTH)) begin
                count_d = count_q + cnt_t'(1);
            end
        end else if (pop) begin
            if (count_q != '0) begin
                sp_d    = sp_q - sp_t'(1);
                count_d = count_q - cnt_t'(1);
            end else begin
                underflow_d = 1'b1;
            end
        end

        if (commit_ok) begin
            slot_valid_d[head_q] = 1'b0;
            head_d               = head_q + id_t'(1);
        end

        if (restore_ok) begin
            // Squash the restored tag and everything allocated after it.
            for (int i = 0; i < CKPT_NUM; i++) begin
                if (id_t'(id_t'(i) - head_q) >= rpos) begin
                    slot_valid_d[i] = 1'b0;
                end
            end
            // Committing the very slot being restored leaves the queue empty at the new head.
            if (commit_ok && (restore_id == head_q)) begin
                tail_d     = head_d;
                ckpt_cnt_d = '0;
            end else begin
                tail_d     = restore_id;
                ckpt_cnt_d = QW'(id_t'(restore_id - head_d));
            end
        end else begin
            if (save_ok) begin
                slot_valid_d[tail_q] = 1'b1;
                slot_sp_d[tail_q]    = sp_d;
                slot_cnt_d[tail_q]   = count_d;
                slot_top_d[tail_q]   = stack_d[sp_d];
                tail_d               = tail_q + id_t'(1);
            end
            if (save_ok && !commit_ok) begin
                ckpt_cnt_d = ckpt_cnt_q + QW'(1);
            end else if (!save_ok && commit_ok) begin
                ckpt_cnt_d = ckpt_cnt_q - QW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q         <= '0;
            count_q      <= '0;
            underflow_q  <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            ckpt_cnt_q   <= '0;
            slot_valid_q <= '0;
        end else begin
            sp_q         <= sp_d;
            count_q      <= count_d;
            underflow_q  <= underflow_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            ckpt_cnt_q   <= ckpt_cnt_d;
            slot_valid_q <= slot_valid_d;
        end
    end

    // Storage arrays carry no reset; validity is tracked by count and slot_valid.
    always_ff @(posedge clk) begin
        stack_q    <= stack_d;
        slot_sp_q  <= slot_sp_d;
        slot_cnt_q <= slot_cnt_d;
        slot_top_q <= slot_top_d;
    end
endmodule

// File: tb/tb_ras_ckpt.sv
// Scoreboard bench for ras_ckpt: driver predicts with a queue-based model, monitor compares.
module tb_ras_ckpt;
    logic        clk;
    logic        rst_n;
    logic        push;
    logic        pop;
    logic [31:0] din;
    logic [31:0] top_data;
    logic        top_valid;
    logic        underflow;
    logic        ckpt_save;
    logic [1:0]  ckpt_id;
    logic        ckpt_full;
    logic        restore;
    logic [1:0]  restore_id;
    logic        commit;

    int n_cmp = 0;
    int n_err = 0;

    ras_ckpt #(.DATA_WIDTH(32), .STACK_ADDR_WIDTH(4), .CKPT_ID_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din),
        .top_data(top_data), .top_valid(top_valid), .underflow(underflow),
        .ckpt_save(ckpt_save), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
        .restore(restore), .restore_id(restore_id), .commit(commit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        tv;
        logic [31:0] td;
        logic        uf;
        logic        full;
        logic [1:0]  id;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int          tag;
        int          sp;
        int          cnt;
        logic [31:0] top;
    } ck_t;

    logic [31:0] m_mem [16];
    int          m_sp;
    int          m_cnt;
    bit          m_uf;
    int          m_tag;
    ck_t         m_ck[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit ps, input bit pp, input logic [31:0] d, input bit sv,
                         input bit rs, input logic [1:0] rid, input bit cm, input bit rn);
        int  r_idx;
        bit  r_ok, c_ok, full;
        ck_t rec;
        if (!rn) begin
            m_sp = 0; m_cnt = 0; m_uf = 0; m_tag = 0;
            m_ck.delete();
            return;
        end
        m_uf  = 0;
        r_idx = -1;
        foreach (m_ck[i]) if (m_ck[i].tag == int'(rid)) r_idx = i;
        r_ok = rs && (r_idx >= 0);
        c_ok = cm && (m_ck.size() > 0);
        full = (m_ck.size() == 4);
        if (r_ok) begin
            rec = m_ck[r_idx];
            m_sp = rec.sp; m_cnt = rec.cnt; m_mem[m_sp] = rec.top;
        end else if (ps && pp) begin
            m_mem[m_sp] = d;
        end else if (ps) begin
            m_sp = (m_sp + 1) % 16;
            m_mem[m_sp] = d;
            if (m_cnt < 16) m_cnt++;
        end else if (pp) begin
            if (m_cnt > 0) begin
                m_sp = (m_sp + 15) % 16;
                m_cnt--;
            end else begin
                m_uf = 1;
            end
        end
        if (r_ok) begin
            while (m_ck.size() > r_idx) void'(m_ck.pop_back());
            if (c_ok && m_ck.size() > 0) void'(m_ck.pop_front());
            m_tag = (c_ok && r_idx == 0) ? (int'(rid) + 1) % 4 : int'(rid);
        end else begin
            if (c_ok) void'(m_ck.pop_front());
            if (sv && (!full || c_ok)) begin
                rec.tag = m_tag; rec.sp = m_sp; rec.cnt = m_cnt; rec.top = m_mem[m_sp];
                m_ck.push_back(rec);
                m_tag = (m_tag + 1) % 4;
            end
        end
    endtask

    task automatic step(input bit ps, input bit pp, input logic [31:0] d, input bit sv,
                        input bit rs, input logic [1:0] rid, input bit cm, input bit rn);
        exp_t e;
        @(negedge clk);
        push = ps; pop = pp; din = d; ckpt_save = sv;
        restore = rs; restore_id = rid; commit = cm; rst_n = rn;
        model(ps, pp, d, sv, rs, rid, cm, rn);
        e.tv = (m_cnt != 0); e.td = m_mem[m_sp]; e.uf = m_uf;
        e.full = (m_ck.size() == 4); e.id = 2'(m_tag);
        exp_q.push_back(e);
    endtask

    task automatic t_reset();           step(0, 0, 32'h0, 0, 0, 2'd0, 0, 0); endtask
    task automatic t_push(input logic [31:0] d); step(1, 0, d, 0, 0, 2'd0, 0, 1); endtask
    task automatic t_pop();             step(0, 1, 32'h0, 0, 0, 2'd0, 0, 1); endtask
    task automatic t_save();            step(0, 0, 32'h0, 1, 0, 2'd0, 0, 1); endtask
    task automatic t_restore(input logic [1:0] id); step(0, 0, 32'h0, 0, 1, id, 0, 1); endtask
    task automatic after_edge();        @(posedge clk); #2; endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("top_valid", 32'(top_valid), 32'(e.tv));
                chk("underflow", 32'(underflow), 32'(e.uf));
                chk("ckpt_full", 32'(ckpt_full), 32'(e.full));
                chk("ckpt_id", 32'(ckpt_id), 32'(e.id));
                if (e.tv) chk("top_data", top_data, e.td);
            end
        end
    end

    initial begin
        push = 0; pop = 0; din = '0; ckpt_save = 0; restore = 0; restore_id = '0; commit = 0;
        rst_n = 0;

        t_reset(); t_reset();
        after_edge();
        chk("rst_top_valid", 32'(top_valid), 32'd0);
        chk("rst_ckpt_id", 32'(ckpt_id), 32'd0);
        t_push(32'h100); t_push(32'h200); t_push(32'h300);
        after_edge(); chk("seq_top3", top_data, 32'h300);
        t_pop(); after_edge(); chk("seq_pop1", top_data, 32'h200);
        t_pop(); after_edge(); chk("seq_pop2", top_data, 32'h100);
        t_pop(); after_edge(); chk("seq_empty", 32'(top_valid), 32'd0);
        t_pop(); after_edge(); chk("seq_underflow", 32'(underflow), 32'd1);
        t_pop(); t_reset();

        for (int i = 0; i < 17; i++) t_push(32'h1000 + 32'(4 * i));
        after_edge(); chk("ovf_top", top_data, 32'h1040);
        t_pop(); after_edge(); chk("ovf_pop1", top_data, 32'h103C);
        for (int i = 1; i < 16; i++) t_pop();
        after_edge(); chk("ovf_empty", 32'(top_valid), 32'd0);
        t_pop(); after_edge(); chk("ovf_underflow", 32'(underflow), 32'd1);

        t_reset();
        t_push(32'hA0); t_save(); t_pop(); t_push(32'hB0);
        after_edge(); chk("rep_spec_top", top_data, 32'hB0);
        t_restore(2'd0);
        after_edge(); chk("rep_top", top_data, 32'hA0);
        chk("rep_valid", 32'(top_valid), 32'd1);

        t_reset();
        for (int i = 0; i < 4; i++) begin
            t_save();
            chk("full_id", 32'(ckpt_id), 32'(i));
        end
        after_edge(); chk("full_flag", 32'(ckpt_full), 32'd1);
        t_save(); after_edge(); chk("full_ignored_id", 32'(ckpt_id), 32'd0);
        step(0, 0, 32'h0, 1, 0, 2'd0, 1, 1);
        chk("cs_id", 32'(ckpt_id), 32'd0);
        after_edge(); chk("cs_full", 32'(ckpt_full), 32'd1);

        t_reset();
        step(1, 0, 32'h10, 1, 0, 2'd0, 0, 1); chk("sq_id0", 32'(ckpt_id), 32'd0);
        step(1, 0, 32'h20, 1, 0, 2'd0, 0, 1); chk("sq_id1", 32'(ckpt_id), 32'd1);
        step(1, 0, 32'h30, 1, 0, 2'd0, 0, 1);
        t_restore(2'd1); after_edge(); chk("sq_top", top_data, 32'h20);
        t_push(32'h40);
        t_restore(2'd2); after_edge(); chk("sq_ign_top", top_data, 32'h40);
        t_save(); chk("sq_next_id", 32'(ckpt_id), 32'd1);

        t_reset();
        t_push(32'h44);
        step(1, 1, 32'h55, 0, 0, 2'd0, 0, 1);
        after_edge(); chk("pp_top", top_data, 32'h55);
        t_save(); t_push(32'h66);
        step(1, 0, 32'h77, 0, 1, 2'd0, 0, 1);
        after_edge(); chk("rp_top", top_data, 32'h55);

        t_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                t_reset();
            end else begin
                step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4, $urandom,
                     $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                     2'($urandom_range(0, 3)), $urandom_range(0, 9) < 2, 1);
            end
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d pending expectations, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
